// File: rtl/sensor_trafficlights.sv
// Demand-actuated two-road junction controller (UK light sequence).
// Road A rests on green; opposing-road demand is latched and drives the cycle.
module sensor_trafficlights #(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned AMBER     = 2,
  parameter int unsigned ALLRED    = 1,
  parameter int unsigned REDAMBER  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       carA,
  input  logic       carB,
  output logic [2:0] lightsA,
  output logic [2:0] lightsB
);

  localparam int unsigned MAX_01 = (MIN_GREEN > AMBER) ? MIN_GREEN : AMBER;
  localparam int unsigned MAX_23 = (ALLRED > REDAMBER) ? ALLRED : REDAMBER;
  localparam int unsigned MAXP   = (MAX_01 > MAX_23) ? MAX_01 : MAX_23;
  localparam int unsigned TMR_W  = $clog2(MAXP) + 1;

  localparam logic [TMR_W-1:0] GREEN_LAST    = TMR_W'(MIN_GREEN - 1);
  localparam logic [TMR_W-1:0] AMBER_LAST    = TMR_W'(AMBER - 1);
  localparam logic [TMR_W-1:0] ALLRED_LAST   = TMR_W'(ALLRED - 1);
  localparam logic [TMR_W-1:0] REDAMBER_LAST = TMR_W'(REDAMBER - 1);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] REDAMB = 3'b110;
  localparam logic [2:0] AMB    = 3'b010;
  localparam logic [2:0] GRN    = 3'b001;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_AMBER  = 3'd1,
    RED_AB   = 3'd2,
    B_REDAMB = 3'd3,
    B_GREEN  = 3'd4,
    B_AMBER  = 3'd5,
    RED_BA   = 3'd6,
    A_REDAMB = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             reqa_q, reqa_d;
  logic             reqb_q, reqb_d;
  logic [2:0]       lightsa_q, lightsb_q;
  logic             entering;
  logic             in_green;

  // Lamp pattern {lightsA, lightsB} for a given state.
  function automatic logic [5:0] decode(input state_e s);
    case (s)
      A_GREEN:  decode = {GRN,    RED};
      A_AMBER:  decode = {AMB,    RED};
      RED_AB:   decode = {RED,    RED};
      B_REDAMB: decode = {RED,    REDAMB};
      B_GREEN:  decode = {RED,    GRN};
      B_AMBER:  decode = {RED,    AMB};
      RED_BA:   decode = {RED,    RED};
      A_REDAMB: decode = {REDAMB, RED};
      default:  decode = {RED,    RED};
    endcase
  endfunction

  // Next-state: greens wait for opposing demand, all other states are timed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      A_GREEN:  if (tmr_q >= GREEN_LAST && (reqb_q || carB)) state_d = A_AMBER;
      A_AMBER:  if (tmr_q == AMBER_LAST)    state_d = RED_AB;
      RED_AB:   if (tmr_q == ALLRED_LAST)   state_d = B_REDAMB;
      B_REDAMB: if (tmr_q == REDAMBER_LAST) state_d = B_GREEN;
      B_GREEN:  if (tmr_q >= GREEN_LAST && (reqa_q || carA)) state_d = B_AMBER;
      B_AMBER:  if (tmr_q == AMBER_LAST)    state_d = RED_BA;
      RED_BA:   if (tmr_q == ALLRED_LAST)   state_d = A_REDAMB;
      A_REDAMB: if (tmr_q == REDAMBER_LAST) state_d = A_GREEN;
      default:  state_d = A_GREEN;
    endcase
  end

  // Dwell timer and request latches; entering a green clears its own request.
  always_comb begin
    entering = (state_d != state_q);
    in_green = (state_q == A_GREEN) || (state_q == B_GREEN);
    tmr_d    = tmr_q;
    reqa_d   = reqa_q;
    reqb_d   = reqb_q;

    if (entering)                           tmr_d = '0;
    else if (!(in_green && (&tmr_q)))       tmr_d = tmr_q + TMR_W'(1);

    if (entering && state_d == A_GREEN)     reqa_d = 1'b0;
    else if (carA && state_q != A_GREEN)    reqa_d = 1'b1;

    if (entering && state_d == B_GREEN)     reqb_d = 1'b0;
    else if (carB && state_q != B_GREEN)    reqb_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= A_GREEN;
      tmr_q     <= '0;
      reqa_q    <= 1'b0;
      reqb_q    <= 1'b0;
      lightsa_q <= GRN;
      lightsb_q <= RED;
    end else begin
      state_q                  <= state_d;
      tmr_q                    <= tmr_d;
      reqa_q                   <= reqa_d;
      reqb_q                   <= reqb_d;
      {lightsa_q, lightsb_q}   <= decode(state_d);
    end
  end

  assign lightsA = lightsa_q;
  assign lightsB = lightsb_q;

endmodule

// File: tb/tb_sensor_trafficlights.sv
// Directed bench for sensor_trafficlights: lamp patterns checked cycle by cycle
// against hand-derived sequences for the default parameters.
module tb_sensor_trafficlights;

  localparam logic [5:0] AG  = 6'b001_100;
  localparam logic [5:0] AA  = 6'b010_100;
  localparam logic [5:0] RR  = 6'b100_100;
  localparam logic [5:0] BRA = 6'b100_110;
  localparam logic [5:0] BG  = 6'b100_001;
  localparam logic [5:0] BA  = 6'b100_010;
  localparam logic [5:0] ARA = 6'b110_100;

  logic       clk = 1'b0;
  logic       rst;
  logic       carA;
  logic       carB;
  logic [2:0] lightsA;
  logic [2:0] lightsB;

  int n_checks = 0;
  int n_fail   = 0;

  sensor_trafficlights dut (
    .clk     (clk),
    .rst     (rst),
    .carA    (carA),
    .carB    (carB),
    .lightsA (lightsA),
    .lightsB (lightsB)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b_%b expected %b_%b", tag, obs[5:3], obs[2:0], exp[5:3], exp[2:0]);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    carA = 1'b0;
    carB = 1'b0;
    tick();
    rst  = 1'b0;
  endtask

  // One full 16-cycle period with demand on both roads, starting at A green entry.
  function automatic logic [5:0] exp_cycle(input int c);
    int p;
    p = c % 16;
    if (p <= 3)       exp_cycle = AG;
    else if (p <= 5)  exp_cycle = AA;
    else if (p == 6)  exp_cycle = RR;
    else if (p == 7)  exp_cycle = BRA;
    else if (p <= 11) exp_cycle = BG;
    else if (p <= 13) exp_cycle = BA;
    else if (p == 14) exp_cycle = RR;
    else              exp_cycle = ARA;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Idle: rests on A green.
    do_reset();
    for (int c = 0; c < 30; c++) begin
      check_eq($sformatf("idle c%0d", c), {lightsA, lightsB}, AG);
      tick();
    end

    // One-cycle carB pulse, then B green held; carB on B green is ignored.
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      check_eq($sformatf("bpulse c%0d", c), {lightsA, lightsB}, (c < 8) ? exp_cycle(c) : BG);
      carB = (c == 1);
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      check_eq($sformatf("bhold c%0d", c), {lightsA, lightsB}, BG);
      carB = 1'b1;
      tick();
    end
    check_eq("bhold end", {lightsA, lightsB}, BG);
    carA = 1'b1;
    tick();
    carA = 1'b0;
    carB = 1'b0;
    check_eq("apulse amber0", {lightsA, lightsB}, BA);
    tick();
    check_eq("apulse amber1", {lightsA, lightsB}, BA);
    tick();
    check_eq("apulse allred", {lightsA, lightsB}, RR);
    tick();
    check_eq("apulse redamb", {lightsA, lightsB}, ARA);
    tick();
    check_eq("apulse agreen", {lightsA, lightsB}, AG);

    // Continuous demand on both roads: period 16 alternation.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      check_eq($sformatf("both c%0d", c), {lightsA, lightsB}, exp_cycle(c));
      carA = 1'b1;
      carB = 1'b1;
      tick();
    end
    carA = 1'b0;
    carB = 1'b0;

    // carA during B red+amber: B green still lasts the minimum, then back to A.
    do_reset();
    for (int c = 0; c < 26; c++) begin
      check_eq($sformatf("redamb_a c%0d", c), {lightsA, lightsB}, (c < 16) ? exp_cycle(c) : AG);
      carB = (c == 1);
      carA = (c == 7);
      tick();
    end

    // Reset mid B amber with a latched B request: request is discarded.
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      check_eq($sformatf("rstamb c%0d", c), {lightsA, lightsB}, exp_cycle(c));
      carB = (c == 1);
      carA = (c == 11);
      tick();
    end
    check_eq("rstamb c12", {lightsA, lightsB}, BA);
    carA = 1'b0;
    carB = 1'b1;
    tick();
    check_eq("rstamb c13", {lightsA, lightsB}, BA);
    carB = 1'b0;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check_eq($sformatf("post_rst c%0d", c), {lightsA, lightsB}, AG);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
